// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_MUL = 6'b011000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;
   localparam logic [2:0] ALU_SLT = 3'b110;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_t;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
   } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU control decoder: ALU-op class plus funct to ALU_control code.
// MIPS_CTRL_MUL_EN makes funct 011000 (mul) a legal R-type operation.
module alu_decoder
   import mips_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [5:0] funct,
   output logic [2:0] alu_control,
   output logic       funct_illegal
);

   logic [2:0] fn_code;

   // funct_illegal is independent of the class so DECODE can screen R-types early
   always_comb begin
      fn_code       = ALU_ADD;
      funct_illegal = 1'b0;
      case (funct)
         FN_ADD: fn_code = ALU_ADD;
         FN_SUB: fn_code = ALU_SUB;
         FN_AND: fn_code = ALU_AND;
         FN_OR:  fn_code = ALU_OR;
         FN_SLT: fn_code = ALU_SLT;
`ifdef MIPS_CTRL_MUL_EN
         FN_MUL: fn_code = ALU_MUL;
`endif
         default: funct_illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (alu_op)
         ALUOP_ADD:   alu_control = ALU_ADD;
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: alu_control = fn_code;
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch through write-back.
// Optional mul support is selected with the MIPS_CTRL_MUL_EN macro (see alu_decoder).
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W = 6,
   parameter int FN_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] opcode,
   input  logic [FN_W-1:0] funct,
   input  logic            mem_ready,
   input  logic            zero_flag,
   output logic [2:0]      ALU_control,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      pc_src,
   output logic            pc_write,
   output logic            branch,
   output logic            iord,
   output logic            mem_write,
   output logic            ir_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            illegal_op
);

   state_t  state, next_state;
   alu_op_t alu_op;
   logic    funct_illegal;
   logic    is_store;

   // zero_flag is combined with branch in the datapath, not here
   logic    unused_zero_flag;
   assign unused_zero_flag = zero_flag;

   alu_decoder u_alu_decoder (
      .alu_op        (alu_op),
      .funct         (funct),
      .alu_control   (ALU_control),
      .funct_illegal (funct_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= next_state;
   end

   // lw/sw choice is captured in DECODE so MEMADR never looks at the opcode
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 is_store <= 1'b0;
      else if (state == DECODE) is_store <= (opcode == OP_SW);
   end

   always_comb begin
      next_state = state;
      alu_op     = ALUOP_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_RT;
      pc_src     = PCSRC_ALU;
      pc_write   = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
      case (state)
         FETCH: begin
            alu_src_b = SRCB_FOUR;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
            if (mem_ready) next_state = DECODE;
         end
         DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (opcode)
               OP_RTYPE: begin
                  if (funct_illegal) begin
                     illegal_op = 1'b1;
                     next_state = FETCH;
                  end else begin
                     next_state = EXECUTE;
                  end
               end
               OP_LW, OP_SW: next_state = MEMADR;
               OP_BEQ:       next_state = BRANCH;
               OP_ADDI:      next_state = ADDIEXEC;
               OP_J:         next_state = JUMP;
               default: begin
                  illegal_op = 1'b1;
                  next_state = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = is_store ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            iord = 1'b1;
            if (mem_ready) next_state = MEMWB;
         end
         MEMWRITE: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) next_state = FETCH;
         end
         MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         EXECUTE: begin
            alu_op     = ALUOP_FUNCT;
            alu_src_a  = 1'b1;
            next_state = ALUWB;
         end
         ALUWB: begin
            reg_dst    = 1'b1;
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            alu_op     = ALUOP_SUB;
            alu_src_a  = 1'b1;
            pc_src     = PCSRC_ALUOUT;
            branch     = 1'b1;
            next_state = FETCH;
         end
         ADDIEXEC: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = ADDIWB;
         end
         ADDIWB: begin
            reg_write  = 1'b1;
            next_state = FETCH;
         end
         JUMP: begin
            pc_src     = PCSRC_JUMP;
            pc_write   = 1'b1;
            next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: checks the full output vector every cycle.
// Define MIPS_CTRL_MUL_EN for both bench and RTL to exercise the mul path.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       zero_flag;
   logic [2:0] ALU_control;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] pc_src;
   logic       pc_write, branch, iord, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, illegal_op;

   int test_count = 0;
   int fail_count = 0;

   mips_multicycle_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .opcode      (opcode),
      .funct       (funct),
      .mem_ready   (mem_ready),
      .zero_flag   (zero_flag),
      .ALU_control (ALU_control),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .pc_write    (pc_write),
      .branch      (branch),
      .iord        (iord),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   // Packed layout: alu, src_a, src_b, pc_src, pc_write, branch, iord, mem_write,
   // ir_write, reg_dst, mem_to_reg, reg_write, illegal_op
   function automatic logic [16:0] exp_vec(
      input logic [2:0] alu, input logic a, input logic [1:0] b, input logic [1:0] pcs,
      input logic pw, input logic br, input logic io, input logic mw, input logic irw,
      input logic rd, input logic mtr, input logic rw, input logic ill);
      return {alu, a, b, pcs, pw, br, io, mw, irw, rd, mtr, rw, ill};
   endfunction

   logic [16:0] fetch_rdy, fetch_wait, decode_ok, decode_ill, memadr, memread, memwrite;
   logic [16:0] memwb, exec_slt, exec_mul, aluwb, branch_st, addiexec, addiwb, jump_st;

   function automatic logic [16:0] observed();
      return {ALU_control, alu_src_a, alu_src_b, pc_src, pc_write, branch, iord,
              mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal_op};
   endfunction

   task automatic check_output(input string tag, input logic [16:0] expected);
      logic [16:0] obs;
      obs = observed();
      test_count++;
      assert (obs === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %b required %b", tag, obs, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      fetch_rdy  = exp_vec(3'b010, 0, 2'b01, 2'b00, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      fetch_wait = exp_vec(3'b010, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      decode_ok  = exp_vec(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      decode_ill = exp_vec(3'b010, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      memadr     = exp_vec(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      memread    = exp_vec(3'b010, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      memwrite   = exp_vec(3'b010, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      memwb      = exp_vec(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      exec_slt   = exp_vec(3'b110, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exec_mul   = exp_vec(3'b101, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      aluwb      = exp_vec(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      branch_st  = exp_vec(3'b100, 1, 2'b00, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      addiexec   = exp_vec(3'b010, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      addiwb     = exp_vec(3'b010, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      jump_st    = exp_vec(3'b010, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      rst = 1'b1;
      mem_ready = 1'b1;
      zero_flag = 1'b0;
      apply_stimulus(6'b100011, 6'b000000);
      #1;
      check_output("reset_fetch_ready", fetch_rdy);
      mem_ready = 1'b0;
      #1;
      check_output("reset_fetch_wait", fetch_wait);
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;

      // lw: five cycles, write-back only in the last
      check_output("lw_c1_fetch", fetch_rdy);
      step(); check_output("lw_c2_decode", decode_ok);
      step(); check_output("lw_c3_memadr", memadr);
      step(); check_output("lw_c4_memread", memread);
      step(); check_output("lw_c5_memwb", memwb);
      step(); check_output("lw_done_fetch", fetch_rdy);

      // R-type slt
      apply_stimulus(6'b000000, 6'b101010);
      step(); check_output("slt_decode", decode_ok);
      step(); check_output("slt_execute", exec_slt);
      step(); check_output("slt_aluwb", aluwb);
      step(); check_output("slt_done_fetch", fetch_rdy);

      // beq behind a three-cycle fetch stall
      apply_stimulus(6'b000100, 6'b000000);
      mem_ready = 1'b0;
      #1; check_output("beq_wait1", fetch_wait);
      step(); check_output("beq_wait2", fetch_wait);
      step(); check_output("beq_wait3", fetch_wait);
      step(); mem_ready = 1'b1; #1;
      check_output("beq_fetch_ready", fetch_rdy);
      step(); check_output("beq_decode", decode_ok);
      step(); check_output("beq_branch", branch_st);
      step(); check_output("beq_done_fetch", fetch_rdy);

      // sw with two stalled MEMWRITE cycles
      apply_stimulus(6'b101011, 6'b000000);
      step(); check_output("sw_decode", decode_ok);
      step(); check_output("sw_memadr", memadr);
      mem_ready = 1'b0;
      step(); check_output("sw_memwrite1", memwrite);
      step(); check_output("sw_memwrite2", memwrite);
      step(); mem_ready = 1'b1; #1;
      check_output("sw_memwrite3", memwrite);
      step(); check_output("sw_done_fetch", fetch_rdy);

      // unsupported opcode
      apply_stimulus(6'b111111, 6'b000000);
      step(); check_output("illop_decode", decode_ill);
      step(); check_output("illop_fetch", fetch_rdy);

      // mul funct: legal only with the macro
      apply_stimulus(6'b000000, 6'b011000);
`ifdef MIPS_CTRL_MUL_EN
      step(); check_output("mul_decode", decode_ok);
      step(); check_output("mul_execute", exec_mul);
      step(); check_output("mul_aluwb", aluwb);
      step(); check_output("mul_done_fetch", fetch_rdy);
`else
      step(); check_output("mul_decode_illegal", decode_ill);
      step(); check_output("mul_fetch", fetch_rdy);
`endif

      // jump
      apply_stimulus(6'b000010, 6'b000000);
      step(); check_output("j_decode", decode_ok);
      step(); check_output("j_jump", jump_st);
      step(); check_output("j_done_fetch", fetch_rdy);

      // addi complete
      apply_stimulus(6'b001000, 6'b000000);
      step(); check_output("addi_decode", decode_ok);
      step(); check_output("addi_exec", addiexec);
      step(); check_output("addi_wb", addiwb);
      step(); check_output("addi_done_fetch", fetch_rdy);

      // addi aborted by reset in ADDIEXEC
      step(); check_output("abort_decode", decode_ok);
      step(); check_output("abort_exec", addiexec);
      #2 rst = 1'b1;
      #1; check_output("abort_async_fetch", fetch_rdy);
      step(); check_output("abort_held_fetch", fetch_rdy);
      @(negedge clk);
      rst = 1'b0;
      #1; check_output("abort_release_fetch", fetch_rdy);
      step(); check_output("abort_next_decode", decode_ok);
      step(); check_output("abort_rerun_exec", addiexec);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle main controller for the MIPS core. It decodes the instruction opcode and function field and sequences fetch, decode, execute, memory and write-back through a Moore state machine. It drives `ALU_control` and the datapath select and enable strobes, so it is the initiating end of the ALU control interface. It sits between the instruction register and the shared datapath (PC, memory port, register file, ALU).

## Interface
Parameters:
- `OP_W`, 6, opcode width (instr[31:26]).
- `FN_W`, 6, funct width (instr[5:0]).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  from the instruction register.
- `funct`  in  6  from the instruction register.
- `mem_ready`  in  1  memory handshake; the access completes in any cycle where this is high.
- `zero_flag`  in  1  ALU zero output; used only through `branch`, which the datapath ANDs with it.
- `ALU_control`  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT.
- `alu_src_a`  out  1  0 selects PC, 1 selects rs.
- `alu_src_b`  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `pc_src`  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- `pc_write`, `branch`, `iord`, `mem_write`, `ir_write`, `reg_dst`, `mem_to_reg`, `reg_write`  out  1 each  datapath strobes and selects.
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode or funct is unsupported.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
- Outputs are Moore-decoded from state, except `pc_write` and `ir_write` in FETCH. Those two are `mem_ready`-qualified: they are high only when `mem_ready`=1.
- Every output not listed for a state is 0. `ALU_control` defaults to 010.
- Per-state outputs:
  - FETCH: src_a=0, src_b=01, ADD, pc_src=00, `pc_write`/`ir_write`=mem_ready. Stays in FETCH until `mem_ready`.
  - DECODE: src_a=0, src_b=11, ADD (precomputes the branch target).
  - MEMADR: src_a=1, src_b=10, ADD.
  - MEMREAD: iord=1. Stays until `mem_ready`, then goes to MEMWB.
  - MEMWRITE: iord=1, mem_write=1. Stays until `mem_ready`, then goes to FETCH.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1.
  - EXECUTE: src_a=1, src_b=00, `ALU_control` from funct: 100000→010, 100010→100, 100100→000, 100101→001, 101010→110, 011000→101.
  - ALUWB: reg_dst=1, reg_write=1.
  - BRANCH: src_a=1, src_b=00, SUB, pc_src=01, branch=1.
  - ADDIEXEC: src_a=1, src_b=10, ADD.
  - ADDIWB: reg_dst=0, reg_write=1.
  - JUMP: pc_src=10, pc_write=1.
- DECODE dispatch:
  - 000000 → EXECUTE.
  - 100011 or 101011 → MEMADR. MEMADR then goes to MEMREAD for lw, MEMWRITE for sw.
  - 000100 → BRANCH.
  - 001000 → ADDIEXEC.
  - 000010 → JUMP.
  - Any other opcode, or opcode 000000 with an unmapped funct: `illegal_op`=1 and next state FETCH. No register or memory write occurs.
- Terminal states MEMWB, ALUWB, BRANCH, ADDIWB and JUMP go to FETCH unconditionally.

## Timing
- Reset: state=FETCH asynchronously. Outputs during and after reset take the FETCH values: src_b=01, `ALU_control`=010, all others 0, and `pc_write`/`ir_write` follow `mem_ready`.
- Latency with `mem_ready` tied high: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds one cycle. No strobe repeats during a wait, and `mem_write` stays high for the whole MEMWRITE wait.
- Reset asserted mid-instruction aborts it immediately. No pending `reg_write` or `mem_write` is issued after reset deasserts.
- `opcode` and `funct` are sampled only in DECODE and EXECUTE. The instruction register is stable in those states because `ir_write` is 0 there.

## Configuration
- `MIPS_CTRL_MUL_EN` defined: funct 011000 decodes to `ALU_control`=101, and the instruction completes through ALUWB.
- Not defined: funct 011000 is illegal. `illegal_op` pulses and the controller returns to FETCH with no write.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the opcode and funct constants;
  - the `ALU_control` codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SLT;
  - the state enum typedef;
  - the alu_src_b and pc_src select constants.
- One sub-module, `alu_decoder`: combinational mapping from a 2-bit ALU-op class (add / sub / funct) plus funct to `ALU_control` and a funct-illegal flag. It is instantiated once, and the FSM owns only the class.

## Test plan
- Reset with `mem_ready`=1, then lw (opcode 100011): state trace FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. `reg_write`=1 with `mem_to_reg`=1 only in cycle 5.
- R-type funct 101010: `ALU_control`=110 in EXECUTE, then ALUWB with `reg_dst`=1, `reg_write`=1. Total 4 cycles.
- beq with `mem_ready` low for 3 cycles in FETCH: a single `pc_write`/`ir_write` pulse when `mem_ready` rises. BRANCH shows `ALU_control`=100, `branch`=1, `pc_src`=01.
- sw with `mem_ready` held low 2 cycles in MEMWRITE: `mem_write`=1 for 3 consecutive cycles, then FETCH.
- Opcode 111111, and funct 011000 built without `MIPS_CTRL_MUL_EN`: `illegal_op`=1 for exactly one cycle and `reg_write` stays 0. With the macro defined, funct 011000 gives `ALU_control`=101.
- `rst` pulsed during ADDIEXEC: next state FETCH and `reg_write` never asserts for the aborted addi.
